i_set_shaper: RTL and testbench



---
 rtl/i_set_shaper.sv | 252 +++++++++++++++++++++++++
 tb/tb_i_set_shaper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/i_set_shaper.sv
// Discharge-pulse current reference: rectangle, trapezoid/triangle and resistor modes.
// Optional peak clamp to I_MAX is built when I_SET_SHAPER_CLAMP_EN is defined.
module i_set_shaper #(
  parameter int unsigned     DW    = 16,
  parameter int unsigned     TW    = 32,
  parameter logic [DW-1:0]   I_MAX = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] ip,
  input  logic [TW-1:0] t_rise,
  input  logic [TW-1:0] t_hold,
  input  logic [TW-1:0] t_fall,
  output logic [DW-1:0] i_set,
  output logic          pulse_active,
  output logic          busy,
  output logic          done,
  output logic          clamped
);

  localparam int unsigned PW = (TW > DW) ? TW : DW;
  localparam int unsigned RW = PW + 1;

  typedef enum logic [2:0] {
    StIdle, StPrepR, StPrepF, StRise, StHold, StFall, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] pk_q, pk_d;
  logic [TW-1:0] tr_q, tr_d, th_q, th_d, tf_q, tf_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] acc_q, acc_d;
  logic [DW-1:0] i_set_q, i_set_d;
  logic [PW-1:0] prem_q, prem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] q_r_q, q_r_d, q_f_q, q_f_d;
  logic [TW-1:0] rem_r_q, rem_r_d, rem_f_q, rem_f_d;

  logic          idle, accept;
  logic [DW-1:0] pk_in, pk_sel;
  logic [1:0]    mode_sel;
  logic          tr_nz, th_nz, tf_nz;

  assign idle     = (state_q == StIdle);
  assign accept   = idle && start && !abort && (mode != 2'b11);
  assign mode_sel = idle ? mode : mode_q;
  assign pk_sel   = idle ? pk_in : pk_q;
  // Segment sequencing looks at live inputs while idle, latched values afterwards.
  assign tr_nz    = idle ? |t_rise : |tr_q;
  assign th_nz    = idle ? |t_hold : |th_q;
  assign tf_nz    = idle ? |t_fall : |tf_q;

`ifdef I_SET_SHAPER_CLAMP_EN
  logic over;
  logic clamped_q;
  assign over  = (ip > I_MAX);
  assign pk_in = over ? I_MAX : ip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clamped_q <= 1'b0;
    end else if (accept) begin
      clamped_q <= over;
    end else if (state_d == StIdle) begin
      clamped_q <= 1'b0;
    end
  end
  assign clamped = clamped_q;
`else
  logic unused_i_max;
  assign unused_i_max = ^I_MAX;
  assign pk_in        = ip;
  assign clamped      = 1'b0;
`endif

  // One restoring-division step per PREP cycle; dividend shifts out of quo_q MSB-first.
  logic [TW-1:0] div_den;
  logic [RW-1:0] shifted;
  logic          div_ge, div_last;
  logic [PW-1:0] prem_nx;
  logic [DW-1:0] quo_nx;

  assign div_den  = (state_q == StPrepF) ? tf_q : tr_q;
  assign shifted  = {prem_q, quo_q[DW-1]};
  assign div_ge   = (shifted >= RW'(div_den));
  assign prem_nx  = PW'(div_ge ? shifted - RW'(div_den) : shifted);
  assign quo_nx   = {quo_q[DW-2:0], div_ge};
  assign div_last = (cnt_q == TW'(DW - 1));

  // Ramp step: acc carries the fractional part of ip*k/t so no divider runs per cycle.
  logic [TW-1:0] ramp_den, ramp_rem;
  logic [DW-1:0] ramp_step;
  logic [TW:0]   ramp_sum;
  logic          ramp_cy;

  assign ramp_den  = (state_q == StFall) ? tf_q : tr_q;
  assign ramp_rem  = (state_q == StFall) ? rem_f_q : rem_r_q;
  assign ramp_step = (state_q == StFall) ? q_f_q : q_r_q;
  assign ramp_sum  = {1'b0, acc_q} + {1'b0, ramp_rem};
  assign ramp_cy   = (ramp_sum >= {1'b0, ramp_den});

  // Quotients may be finishing this very cycle, so take them straight from the divider.
  logic [DW-1:0] q_r_sel, q_f_sel;
  logic [TW-1:0] rem_r_sel, rem_f_sel;

  assign q_r_sel   = (state_q == StPrepR) ? quo_nx : q_r_q;
  assign rem_r_sel = (state_q == StPrepR) ? TW'(prem_nx) : rem_r_q;
  assign q_f_sel   = (state_q == StPrepF) ? quo_nx : q_f_q;
  assign rem_f_sel = (state_q == StPrepF) ? TW'(prem_nx) : rem_f_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pk_d    = pk_q;
    tr_d    = tr_q;
    th_d    = th_q;
    tf_d    = tf_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    i_set_d = i_set_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    q_r_d   = q_r_q;
    q_f_d   = q_f_q;
    rem_r_d = rem_r_q;
    rem_f_d = rem_f_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d = mode;
          pk_d   = pk_in;
          tr_d   = t_rise;
          th_d   = t_hold;
          tf_d   = t_fall;
          if (mode == 2'b01) begin
            state_d = tr_nz ? StPrepR : tf_nz ? StPrepF : th_nz ? StHold : StDone;
          end else begin
            state_d = th_nz ? StHold : StDone;
          end
        end
      end
      StPrepR, StPrepF: begin
        prem_d = prem_nx;
        quo_d  = quo_nx;
        cnt_d  = cnt_q + TW'(1);
        if (div_last) begin
          if (state_q == StPrepR) begin
            q_r_d   = quo_nx;
            rem_r_d = TW'(prem_nx);
            state_d = tf_nz ? StPrepF : StRise;
          end else begin
            q_f_d   = quo_nx;
            rem_f_d = TW'(prem_nx);
            state_d = tr_nz ? StRise : th_nz ? StHold : StFall;
          end
        end
      end
      StRise, StFall: begin
        acc_d = TW'(ramp_cy ? ramp_sum - {1'b0, ramp_den} : ramp_sum);
        cnt_d = cnt_q + TW'(1);
        if (state_q == StRise) begin
          i_set_d = i_set_q + ramp_step + DW'(ramp_cy);
          if (cnt_q == tr_q) state_d = th_nz ? StHold : tf_nz ? StFall : StDone;
        end else begin
          i_set_d = i_set_q - ramp_step - DW'(ramp_cy);
          if (cnt_q == tf_q) state_d = StDone;
        end
      end
      StHold: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == th_q) state_d = (mode_q == 2'b01 && tf_nz) ? StFall : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && !idle) state_d = StIdle;

    // Entry actions: load the first value of the segment being entered.
    if (state_d != state_q) begin
      case (state_d)
        StPrepR, StPrepF: begin
          prem_d = '0;
          quo_d  = pk_sel;
          cnt_d  = '0;
        end
        StRise: begin
          cnt_d   = TW'(1);
          acc_d   = rem_r_sel;
          i_set_d = q_r_sel;
        end
        StHold: begin
          cnt_d   = TW'(1);
          i_set_d = (mode_sel == 2'b10) ? '0 : pk_sel;
        end
        StFall: begin
          cnt_d   = TW'(1);
          acc_d   = rem_f_sel;
          i_set_d = pk_q - q_f_sel;
        end
        default: i_set_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= '0;
      pk_q    <= '0;
      tr_q    <= '0;
      th_q    <= '0;
      tf_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      i_set_q <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      q_r_q   <= '0;
      q_f_q   <= '0;
      rem_r_q <= '0;
      rem_f_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pk_q    <= pk_d;
      tr_q    <= tr_d;
      th_q    <= th_d;
      tf_q    <= tf_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      i_set_q <= i_set_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      q_r_q   <= q_r_d;
      q_f_q   <= q_f_d;
      rem_r_q <= rem_r_d;
      rem_f_q <= rem_f_d;
    end
  end

  assign i_set        = i_set_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign pulse_active = (state_q == StRise) || (state_q == StHold) || (state_q == StFall);

endmodule

// File: tb/tb_i_set_shaper.sv
// Randomised bench for i_set_shaper against a per-cycle waveform model built from the
// pulse formulas; clamp expectations follow I_SET_SHAPER_CLAMP_EN.
module tb_i_set_shaper;

  localparam int unsigned DW   = 16;
  localparam int unsigned TW   = 32;
  localparam int          IMAX = 800;

  logic          clk, rst, start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] ip;
  logic [TW-1:0] t_rise, t_hold, t_fall;
  logic [DW-1:0] i_set;
  logic          pulse_active, busy, done, clamped;

  i_set_shaper #(
    .DW    (DW),
    .TW    (TW),
    .I_MAX (16'(IMAX))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .ip           (ip),
    .t_rise       (t_rise),
    .t_hold       (t_hold),
    .t_fall       (t_fall),
    .i_set        (i_set),
    .pulse_active (pulse_active),
    .busy         (busy),
    .done         (done),
    .clamped      (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int i;
    bit pa;
    bit bz;
    bit dn;
    bit cl;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(int i, bit pa, bit bz, bit dn, bit cl);
    exp_t e;
    e.i = i; e.pa = pa; e.bz = bz; e.dn = dn; e.cl = cl;
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    check("i_set", 32'(i_set), 32'(e.i));
    check("pulse_active", 32'(pulse_active), 32'(e.pa));
    check("busy", 32'(busy), 32'(e.bz));
    check("done", 32'(done), 32'(e.dn));
    check("clamped", 32'(clamped), 32'(e.cl));
  endtask

  // Expected output of every busy cycle after an accepted start.
  task automatic build_model(input int m, input int ip_v, input int tr, input int th,
                             input int tf);
    longint pk;
    bit     cl;
    exp_q.delete();
    pk = ip_v;
    cl = 1'b0;
`ifdef I_SET_SHAPER_CLAMP_EN
    if (ip_v > IMAX) begin
      pk = IMAX;
      cl = 1'b1;
    end
`endif
    if (m == 3) return;
    if (m == 1) begin
      repeat (16 * (int'(tr != 0) + int'(tf != 0))) exp_q.push_back(mk(0, 0, 1, 0, cl));
      for (int k = 1; k <= tr; k++) exp_q.push_back(mk(int'(pk * k / tr), 1, 1, 0, cl));
      repeat (th) exp_q.push_back(mk(int'(pk), 1, 1, 0, cl));
      for (int k = 1; k <= tf; k++) exp_q.push_back(mk(int'(pk - pk * k / tf), 1, 1, 0, cl));
    end else begin
      repeat (th) exp_q.push_back(mk((m == 2) ? 0 : int'(pk), 1, 1, 0, cl));
    end
    exp_q.push_back(mk(0, 0, 1, 1, cl));
  endtask

  // cut_at = n interrupts after the n-th busy cycle, by abort or by async reset.
  task automatic run_pulse(input int m, input int ip_v, input int tr, input int th,
                           input int tf, input int cut_at, input bit cut_rst, input bit noise);
    build_model(m, ip_v, tr, th, tf);
    @(negedge clk);
    mode   = 2'(m);
    ip     = ip_v[15:0];
    t_rise = tr;
    t_hold = th;
    t_fall = tf;
    abort  = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check_out(exp_q[i]);
      if (noise) begin
        mode   = 2'($urandom_range(0, 3));
        ip     = 16'($urandom);
        t_rise = $urandom_range(0, 20);
        t_hold = $urandom_range(0, 20);
        t_fall = $urandom_range(0, 20);
        start  = ($urandom_range(0, 4) == 0);
      end
      if (cut_at == i + 1) begin
        start = 1'b0;
        if (cut_rst) begin
          #2 rst = 1'b1;
          #1 check_out(mk(0, 0, 0, 0, 0));
          @(negedge clk);
          rst = 1'b0;
        end else begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check_out(mk(0, 0, 0, 0, 0));
        end
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_out(mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, ipv, tr, th, tf, cut;
    bit crst;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = '0;
    ip     = '0;
    t_rise = '0;
    t_hold = '0;
    t_fall = '0;
    @(posedge clk);
    #1 check_out(mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    run_pulse(0, 500, 5, 3, 7, 0, 0, 0);      // rectangle, ramps ignored
    run_pulse(1, 10, 3, 2, 3, 0, 0, 1);       // trapezoid with input noise and stray starts
    run_pulse(1, 1000, 4, 0, 0, 0, 0, 0);     // rise-only triangle
    run_pulse(1, 1000, 8, 2, 4, 35, 0, 0);    // abort on third rise cycle
    run_pulse(3, 1234, 2, 2, 2, 0, 0, 0);     // reserved mode ignored
    run_pulse(2, 700, 3, 4, 3, 0, 0, 0);      // resistor: zero plateau
    run_pulse(1, 0, 5, 2, 3, 0, 0, 0);        // zero peak
    run_pulse(1, 1000, 2, 1, 8, 38, 1, 0);    // async reset mid-fall
    run_pulse(0, 99, 0, 0, 0, 0, 0, 0);       // straight to done
    run_pulse(1, 777, 0, 0, 5, 0, 0, 0);      // fall-only
    run_pulse(1, 65535, 7, 1, 9, 0, 0, 1);    // full-scale peak
    run_pulse(0, 1000, 0, 2, 0, 0, 0, 0);     // clamp case when enabled
    run_pulse(1, 5000, 3, 1, 3, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      m    = $urandom_range(0, 3);
      ipv  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
      tr   = $urandom_range(0, 9);
      th   = $urandom_range(0, 5);
      tf   = $urandom_range(0, 9);
      cut  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 70) : 0;
      crst = $urandom_range(0, 1) == 1;
      run_pulse(m, ipv, tr, th, tf, cut, crst, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
